// File: rtl/hsv_core_commit_arbiter_if.sv
// Producer/commit handshake bundle for hsv_core_commit_arbiter: the N producer
// channels, the single commit channel and the flush request/acknowledge pair.
interface hsv_core_commit_arbiter_if #(
    parameter int N_PORTS = 4,
    parameter int WIDTH   = 64
);
    logic                       flush_req;
    logic                       flush_ack;
    logic [N_PORTS*WIDTH-1:0]   in_data;
    logic [N_PORTS-1:0]         valid_i;
    logic [N_PORTS-1:0]         ready_o;
    logic [WIDTH-1:0]           commit_data;
    logic                       valid_o;
    logic                       ready_i;

    modport slave (
        input  flush_req, in_data, valid_i, ready_i,
        output flush_ack, ready_o, commit_data, valid_o
    );

    modport master (
        output flush_req, in_data, valid_i, ready_i,
        input  flush_ack, ready_o, commit_data, valid_o
    );
endinterface

// File: rtl/hsv_core_commit_arbiter.sv
// Round-robin merge of execution-unit results into one registered commit slot.
// Optional HSV_COMMIT_ARB_STATS_EN adds a saturating stall_cycles counter.
module hsv_core_commit_arbiter #(
    parameter int N_PORTS = 4,
    parameter int WIDTH   = 64
) (
    input  logic                        clk_core,
    input  logic                        rst_core,
    hsv_core_commit_arbiter_if.slave    bus
`ifdef HSV_COMMIT_ARB_STATS_EN
   ,output logic [31:0]                 stall_cycles
`endif
);
    localparam int PTR_W = $clog2(N_PORTS);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   cand, grant_idx;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               flush_ack_q;
    logic [N_PORTS-1:0] grant_oh;
    logic               grant_found;
    logic               slot_free;
    logic               accept;

    // Pointer wrap compares against the last port so non-power-of-two counts work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_PORTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        grant_oh    = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = ptr_q;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!grant_found && bus.valid_i[cand]) begin
                grant_found     = 1'b1;
                grant_idx       = cand;
                grant_oh[cand]  = 1'b1;
            end
            cand = ptr_inc(cand);
        end
    end

    assign slot_free   = ~valid_q | bus.ready_i;
    assign accept      = slot_free & ~bus.flush_req & grant_found;
    assign bus.ready_o = (accept & ~rst_core) ? grant_oh : '0;

    // Flush discards the slot even when the commit stage would have taken it.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (bus.flush_req) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
            ptr_d   = ptr_inc(grant_idx);
        end else if (bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            ptr_q       <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            flush_ack_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            flush_ack_q <= bus.flush_req;
        end
    end

    assign bus.commit_data = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.flush_ack   = flush_ack_q;

`ifdef HSV_COMMIT_ARB_STATS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (valid_q && !bus.ready_i && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_hsv_core_commit_arbiter.sv
// Randomized and directed bench for hsv_core_commit_arbiter (N_PORTS=4, WIDTH=64)
// against a queue-free behavioural model of the round-robin commit slot.
module tb_hsv_core_commit_arbiter;
    localparam int N = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hsv_core_commit_arbiter_if #(.N_PORTS(N), .WIDTH(W)) bus ();

`ifdef HSV_COMMIT_ARB_STATS_EN
    logic [31:0] stall_cycles;
`endif

    hsv_core_commit_arbiter #(.N_PORTS(N), .WIDTH(W)) dut (
        .clk_core     (clk),
        .rst_core     (rst),
        .bus          (bus.slave)
`ifdef HSV_COMMIT_ARB_STATS_EN
       ,.stall_cycles (stall_cycles)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_ptr;
    logic        m_valid;
    logic [W-1:0] m_data;
    logic        m_ack;
    logic [N-1:0] m_last;
    int          m_stall;

    task automatic model_reset();
        m_ptr = 0; m_valid = 1'b0; m_data = '0; m_ack = 1'b0; m_last = '0; m_stall = 0;
    endtask

    function automatic logic [N-1:0] m_grant();
        if (bus.flush_req || (m_valid && !bus.ready_i)) return '0;
        for (int k = 0; k < N; k++) begin
            int p = (m_ptr + k) % N;
            if (bus.valid_i[p]) return N'(1 << p);
        end
        return '0;
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic [N-1:0] g;
        logic fl, rdy;
        logic [W-1:0] d;
        int gi;
        g = m_grant(); fl = bus.flush_req; rdy = bus.ready_i; gi = 0;
        for (int i = 0; i < N; i++) if (g[i]) gi = i;
        d = bus.in_data[gi*W +: W];
        if (m_valid && !rdy) m_stall++;
        @(posedge clk); #1;
        m_last = g;
        m_ack  = fl;
        if (fl) m_valid = 1'b0;
        else if (g != '0) begin m_valid = 1'b1; m_data = d; m_ptr = (gi + 1) % N; end
        else if (rdy) m_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.valid_i = 4'b1111; bus.ready_i = 1'b1; bus.flush_req = 1'b0;
        bus.in_data = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.ready_o !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", bus.ready_o); end
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        total++; if (bus.flush_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", bus.flush_ack); end
        total++; if (bus.commit_data !== 64'h0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.commit_data); end
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (bus.ready_o !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", bus.ready_o); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_seq [5] = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA0};
        bus.in_data = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        bus.valid_i = 4'b1111; bus.ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (bus.ready_o !== m_grant()) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, bus.ready_o, m_grant()); end
            tick();
            total++; if (bus.valid_o !== 1'b1 || bus.commit_data !== exp_seq[i]) begin
                bad++; $display("FAIL rr_data[%0d]: got v=%b %h want v=1 %h", i, bus.valid_o, bus.commit_data, exp_seq[i]);
            end
        end
    endtask

    task automatic test_sparse();
        logic [N-1:0] exp_g [3] = '{4'b0001, 4'b0010, 4'b0001};
        bus.valid_i = 4'b0010; bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.ready_o !== exp_g[i]) begin bad++; $display("FAIL sparse_grant[%0d]: got %b want %b", i, bus.ready_o, exp_g[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bus.in_data = {64'h13, 64'h77, 64'h11, 64'h55};
        bus.valid_i = 4'b0001; bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 4'b0100; bus.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (bus.ready_o !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, bus.ready_o); end
            tick();
            total++; if (bus.valid_o !== 1'b1 || bus.commit_data !== 64'h55) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 55", i, bus.valid_o, bus.commit_data);
            end
        end
        bus.ready_i = 1'b1;
        #1;
        total++; if (bus.ready_o !== 4'b0100) begin bad++; $display("FAIL bp_release_ready: got %b want 0100", bus.ready_o); end
        tick();
        total++; if (bus.valid_o !== 1'b1 || bus.commit_data !== 64'h77) begin
            bad++; $display("FAIL bp_release_data: got v=%b %h want v=1 77", bus.valid_o, bus.commit_data);
        end
    endtask

    task automatic test_flush();
        int saved;
        saved = m_ptr;
        bus.valid_i = 4'b1111; bus.ready_i = 1'b1; bus.flush_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (bus.ready_o !== 4'b0000) begin bad++; $display("FAIL flush_ready[%0d]: got %b want 0000", i, bus.ready_o); end
            tick();
            total++; if (bus.valid_o !== 1'b0 || bus.flush_ack !== 1'b1) begin
                bad++; $display("FAIL flush_state[%0d]: got v=%b ack=%b want v=0 ack=1", i, bus.valid_o, bus.flush_ack);
            end
        end
        bus.flush_req = 1'b0; bus.valid_i = 4'b0000;
        tick();
        total++; if (bus.flush_ack !== 1'b0) begin bad++; $display("FAIL flush_ack_fall: got %b want 0", bus.flush_ack); end
        bus.valid_i = 4'b1111;
        #1;
        total++; if (bus.ready_o !== N'(1 << saved)) begin bad++; $display("FAIL flush_ptr_kept: got %b want %b", bus.ready_o, N'(1 << saved)); end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] pend = '0;
        logic [N-1:0] exp_r;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    bus.in_data[i*W +: W] = {$urandom, $urandom};
                end
            end
            bus.valid_i   = pend;
            bus.ready_i   = ($urandom_range(3, 0) != 0);
            bus.flush_req = ($urandom_range(15, 0) == 0);
            #1;
            exp_r = m_grant();
            total++; if (bus.ready_o !== exp_r) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, bus.ready_o, exp_r); end
            tick();
            pend = pend & ~m_last;
            total++; if (bus.valid_o !== m_valid || bus.flush_ack !== m_ack || (m_valid && bus.commit_data !== m_data)) begin
                bad++; $display("FAIL rnd_out[%0d]: got v=%b ack=%b %h want v=%b ack=%b %h", c, bus.valid_o, bus.flush_ack, bus.commit_data, m_valid, m_ack, m_data);
            end
        end
        bus.flush_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.in_data = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        bus.valid_i = 4'b0100; bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.valid_o !== 1'b0 || bus.commit_data !== 64'h0 || bus.ready_o !== 4'b0000 || bus.flush_ack !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got v=%b %h r=%b ack=%b want all zero", bus.valid_o, bus.commit_data, bus.ready_o, bus.flush_ack);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (bus.ready_o !== 4'b0001) begin bad++; $display("FAIL reset_mid_ptr: got %b want 0001", bus.ready_o); end
    endtask

`ifdef HSV_COMMIT_ARB_STATS_EN
    task automatic test_stats();
        total++; if (stall_cycles !== 32'd0) begin bad++; $display("FAIL stats_reset: got %0d want 0", stall_cycles); end
        bus.valid_i = 4'b0001; bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 4'b0000; bus.ready_i = 1'b0;
        repeat (7) tick();
        total++; if (stall_cycles !== 32'd7) begin bad++; $display("FAIL stats_seven: got %0d want 7", stall_cycles); end
        bus.flush_req = 1'b1; bus.ready_i = 1'b1;
        tick();
        bus.flush_req = 1'b0; bus.valid_i = 4'b0001;
        tick();
        bus.valid_i = 4'b0000; bus.ready_i = 1'b0;
        repeat (3) tick();
        total++; if (stall_cycles !== 32'd10 || stall_cycles !== 32'(m_stall)) begin
            bad++; $display("FAIL stats_ten: got %0d want 10 (model %0d)", stall_cycles, m_stall);
        end
        bus.ready_i = 1'b1;
    endtask
`endif

    initial begin
        bus.flush_req = 1'b0; bus.valid_i = '0; bus.ready_i = 1'b0; bus.in_data = '0;
        model_reset();
        test_reset();
        test_round_robin();
        test_sparse();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_mid();
`ifdef HSV_COMMIT_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hsv_core_commit_arbiter.md
Name: hsv_core_commit_arbiter

Overview:
Merges the result channels of the execution units (branch, ALU, memory, ...) into the single commit_data stream consumed by the commit stage. It sits directly downstream of the branch unit's output skid buffer and the sibling units' output buffers. It grants one producer per cycle using round-robin priority and registers the winner into a one-entry output stage. It honours the core-wide flush_req/flush_ack protocol like every execution stage.

Parameters:
N_PORTS, 4, number of producer channels; range 2..8; port 0 is the branch unit.
WIDTH, 64, bit width of one commit_data payload; the integration sets it to the commit_data_t width.

Ports:
clk_core  input  1  core clock; all state changes on its rising edge.
rst_core  input  1  asynchronous, active-high reset.
flush_req  input  1  pipeline flush request.
flush_ack  output  1  flush acknowledge, registered.
in_data  input  N_PORTS*WIDTH  producer payloads; port i occupies bits [i*WIDTH +: WIDTH].
valid_i  input  N_PORTS  per-producer valid.
ready_o  output  N_PORTS  per-producer ready; at most one bit set (one-hot or zero).
commit_data  output  WIDTH  registered payload to commit.
valid_o  output  1  commit_data holds a result.
ready_i  input  1  commit stage accepts commit_data.

Behaviour:
- Clock and reset: one clock (clk_core); reset (rst_core) is asynchronous and active-high.
- Reset values: valid_o=0, commit_data=0, flush_ack=0, round-robin pointer=0. ready_o=0 while rst_core is high.
- Output slot is free when valid_o=0 or (valid_o & ready_i). Accept = slot free & ~flush_req & |valid_i.
- Grant: the first set valid_i bit searched from pointer upward, wrapping modulo N_PORTS. ready_o = grant one-hot when accept, else 0.
- ready_o is combinational from valid_i, valid_o, ready_i and flush_req. It does not depend on in_data.
- Transfer on port i occurs when valid_i[i] & ready_o[i]. On that edge: commit_data<=in_data slice i, valid_o<=1, pointer<=(i+1) mod N_PORTS.
- Pointer is unchanged on cycles with no transfer.
- Latency: one cycle from input transfer to valid_o. Throughput: one result per cycle when ready_i is held high. A pop and a push in the same cycle are allowed.
- No transfer while the slot is full and ready_i=0: valid_o stays 1 and commit_data stays stable. The output channel obeys valid/ready hold rules.
- Producers must hold valid_i and the payload until accepted. The arbiter never drops an asserted valid_i except on flush.
- Flush:
  - While flush_req=1: ready_o=0, and valid_o<=0 on the next edge, even if ready_i=1 in that cycle.
  - flush_ack<=flush_req every cycle, i.e. one cycle of latency, deasserting one cycle after flush_req falls.
  - The pointer is preserved across a flush.
- Simultaneous flush_req and ready_i: the flush wins; the result is discarded and not committed.
- Reset mid-transfer: all state returns to reset values immediately, asynchronously; no partial transfer is visible.
- N_PORTS not a power of two: pointer wrap uses explicit compare-to-(N_PORTS-1), never natural overflow.

Optional Feature:
HSV_COMMIT_ARB_STATS_EN:
- Defined: adds output port stall_cycles (32 bits). It counts cycles with valid_o & ~ready_i, saturates at 0xFFFF_FFFF, resets to 0 on rst_core, and is not cleared by flush.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle: hold rst_core=1 with valid_i=4'b1111 -> ready_o=0, valid_o=0, flush_ack=0. After release, first grant goes to port 0.
- Round-robin: valid_i=4'b1111 held, ready_i=1, payloads 0xA0..0xA3 -> commit_data sequence 0xA0,0xA1,0xA2,0xA3,0xA0, one per cycle.
- Sparse requests: pointer=2 with valid_i=4'b0011 -> port 0 granted. Next cycle port 1 is granted, then port 0.
- Backpressure: slot full with 0x55, ready_i=0 for 5 cycles, valid_i=4'b0100 -> ready_o=0 and commit_data=0x55 stable. When ready_i=1, 0x55 pops and port 2's payload loads the same edge.
- Flush: slot full, flush_req=1 for 2 cycles with ready_i=1 -> valid_o=0 after the first edge, no ready_o pulses, flush_ack high for the 2 cycles following. The pointer value is unchanged.
- Stats, with HSV_COMMIT_ARB_STATS_EN defined: 7 stall cycles, then a flush, then 3 more stall cycles -> stall_cycles=10.
